wb_stage: RTL and testbench

- Write-back stage of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register and signal outputs.
- Selects the write-back value and commits it to the 32x32 general register file and to the HI/LO registers.
- Serves the two ID-stage read ports with write-through bypass.
- Executes SYSCALL as a halt/display service and keeps a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 28 ++
 rtl/wb_regfile.sv | 52 +++++
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the MIPS write-back stage.
package wb_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam int unsigned HALT_CODE_DEF = 10;
    localparam int unsigned DISP_CODE_DEF = 34;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_V0   = 5'd2;
    localparam logic [REG_AW-1:0] REG_A0   = 5'd4;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register bundle feeding the write-back stage.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic [XLEN-1:0]   IR;
    logic [XLEN-1:0]   PC;
    logic [XLEN-1:0]   R1;
    logic [XLEN-1:0]   R2;
    logic [XLEN-1:0]   RD1;
    logic [REG_AW-1:0] WbRegNum;
    logic              RegWrite;
    logic              LOWrite;
    logic              HIWrite;
    logic              JAL;
    logic              SYSCALL;
    logic              MemToReg;

    modport master (
        output IR, PC, R1, R2, RD1, WbRegNum,
        output RegWrite, LOWrite, HIWrite, JAL, SYSCALL, MemToReg
    );

    modport slave (
        input IR, PC, R1, R2, RD1, WbRegNum,
        input RegWrite, LOWrite, HIWrite, JAL, SYSCALL, MemToReg
    );

endinterface

// File: rtl/wb_regfile.sv
// 32x32 GPR file: one synchronous write port, four combinational read ports
// with $0 forced to zero and same-cycle write-through bypass.
module wb_regfile
    import wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic [REG_AW-1:0] ra3_i,
    input  logic [REG_AW-1:0] ra4_i,
    output logic [XLEN-1:0]   rd1_o,
    output logic [XLEN-1:0]   rd2_o,
    output logic [XLEN-1:0]   rd3_o,
    output logic [XLEN-1:0]   rd4_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    function automatic logic [XLEN-1:0] rd_sel(
        input logic [REG_AW-1:0] addr,
        input logic              we,
        input logic [REG_AW-1:0] waddr,
        input logic [XLEN-1:0]   wdata,
        input logic [XLEN-1:0]   stored
    );
        if (addr == REG_ZERO)
            return '0;
        else if (we && (addr == waddr))
            return wdata;
        else
            return stored;
    endfunction

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < NREGS; i++)
                mem_q[i] <= '0;
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd1_o = rd_sel(ra1_i, we_i, waddr_i, wdata_i, mem_q[ra1_i]);
    assign rd2_o = rd_sel(ra2_i, we_i, waddr_i, wdata_i, mem_q[ra2_i]);
    assign rd3_o = rd_sel(ra3_i, we_i, waddr_i, wdata_i, mem_q[ra3_i]);
    assign rd4_o = rd_sel(ra4_i, we_i, waddr_i, wdata_i, mem_q[ra4_i]);

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: result mux, GPR/HI/LO commit, SYSCALL halt/display
// service and retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned HALT_CODE = HALT_CODE_DEF,
    parameter int unsigned DISP_CODE = DISP_CODE_DEF,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              CLR,
    wb_stage_if.slave         wb,
    input  logic [REG_AW-1:0] RA1,
    input  logic [REG_AW-1:0] RA2,
    output logic [XLEN-1:0]   RD_A,
    output logic [XLEN-1:0]   RD_B,
    output logic [XLEN-1:0]   HI_out,
    output logic [XLEN-1:0]   LO_out,
    output logic [XLEN-1:0]   WbData,
    output logic              Halt,
    output logic [XLEN-1:0]   Display,
    output logic [CNT_W-1:0]  RetireCnt
);

    wb_state_e        state_q, state_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  disp_q, disp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  v0, a0;
    logic             run;
    logic             reg_we;

    assign run    = (state_q == ST_RUN);
    assign reg_we = run && wb.RegWrite;

    always_comb begin
        if (wb.JAL)
            WbData = wb.PC + XLEN'(4);
        else if (wb.MemToReg)
            WbData = wb.RD1;
        else
            WbData = wb.R1;
    end

    // v0/a0 use the same bypass as the ID ports so a SYSCALL sees a same-cycle write.
    wb_regfile u_regfile (
        .clk     (clk),
        .clr_i   (CLR),
        .we_i    (reg_we),
        .waddr_i (wb.WbRegNum),
        .wdata_i (WbData),
        .ra1_i   (RA1),
        .ra2_i   (RA2),
        .ra3_i   (REG_V0),
        .ra4_i   (REG_A0),
        .rd1_o   (RD_A),
        .rd2_o   (RD_B),
        .rd3_o   (v0),
        .rd4_o   (a0)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        if (run) begin
            if (wb.HIWrite)
                hi_d = wb.R2;
            if (wb.LOWrite)
                lo_d = wb.R1;
            if (wb.IR != '0)
                cnt_d = cnt_q + CNT_W'(1);
            if (wb.SYSCALL) begin
                if (v0 == XLEN'(HALT_CODE))
                    state_d = ST_HALT;
                else if (v0 == XLEN'(DISP_CODE))
                    disp_d = a0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= ST_RUN;
            hi_q    <= '0;
            lo_q    <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Halt      = (state_q == ST_HALT);
    assign HI_out    = hi_q;
    assign LO_out    = lo_q;
    assign Display   = disp_q;
    assign RetireCnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (counter narrowed to 4 bits).
module tb_wb_stage;
    import wb_stage_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic              clk;
    logic              CLR;
    logic [REG_AW-1:0] RA1, RA2;
    logic [XLEN-1:0]   RD_A, RD_B, HI_out, LO_out, WbData, Display;
    logic              Halt;
    logic [CNT_W-1:0]  RetireCnt;

    int n_assert = 0;
    int n_fail   = 0;

    wb_stage_if bus ();

    wb_stage #(.HALT_CODE(10), .DISP_CODE(34), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .CLR       (CLR),
        .wb        (bus.slave),
        .RA1       (RA1),
        .RA2       (RA2),
        .RD_A      (RD_A),
        .RD_B      (RD_B),
        .HI_out    (HI_out),
        .LO_out    (LO_out),
        .WbData    (WbData),
        .Halt      (Halt),
        .Display   (Display),
        .RetireCnt (RetireCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        bus.IR = '0; bus.PC = '0; bus.R1 = '0; bus.R2 = '0; bus.RD1 = '0;
        bus.WbRegNum = '0; bus.RegWrite = 1'b0; bus.LOWrite = 1'b0;
        bus.HIWrite = 1'b0; bus.JAL = 1'b0; bus.SYSCALL = 1'b0; bus.MemToReg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
        bubble();
        bus.IR = 32'h0000_0020; bus.RegWrite = 1'b1; bus.WbRegNum = rd; bus.R1 = val;
    endtask

    initial begin
        bubble();
        RA1 = '0; RA2 = '0;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        RA1 = 5'd8;
        #1;
        chk("reset_halt", 32'(Halt), 32'h0);
        chk("reset_cnt", 32'(RetireCnt), 32'h0);
        chk("reset_hi", HI_out, 32'h0);
        chk("reset_disp", Display, 32'h0);
        chk("reset_r8", RD_A, 32'h0);

        // ALU write with same-cycle bypass
        alu_write(5'd8, 32'h0000_1234);
        #1;
        chk("alu_wbdata", WbData, 32'h0000_1234);
        chk("alu_bypass", RD_A, 32'h0000_1234);
        tick();
        bubble();
        #1;
        chk("alu_r8", RD_A, 32'h0000_1234);
        chk("alu_cnt", 32'(RetireCnt), 32'd1);

        // Load then JAL
        bubble();
        bus.IR = 32'h8C00_0000; bus.RegWrite = 1'b1; bus.MemToReg = 1'b1;
        bus.RD1 = 32'hDEAD_BEEF; bus.R1 = 32'h0000_1111; bus.WbRegNum = 5'd9;
        #1;
        chk("load_wbdata", WbData, 32'hDEAD_BEEF);
        tick();
        bubble();
        bus.IR = 32'h0C00_0000; bus.RegWrite = 1'b1; bus.JAL = 1'b1;
        bus.PC = 32'h0000_3000; bus.R1 = 32'h0000_2222; bus.WbRegNum = REG_RA;
        #1;
        chk("jal_wbdata", WbData, 32'h0000_3004);
        tick();
        bubble();
        RA1 = 5'd9; RA2 = 5'd31;
        #1;
        chk("load_r9", RD_A, 32'hDEAD_BEEF);
        chk("jal_r31", RD_B, 32'h0000_3004);
        chk("load_jal_cnt", 32'(RetireCnt), 32'd3);

        // $0 protection
        alu_write(5'd0, 32'hFFFF_FFFF);
        RA1 = 5'd0;
        #1;
        chk("zero_same", RD_A, 32'h0);
        tick();
        bubble();
        #1;
        chk("zero_after", RD_A, 32'h0);

        // HI/LO together
        bubble();
        bus.IR = 32'h0000_0018; bus.HIWrite = 1'b1; bus.LOWrite = 1'b1;
        bus.R2 = 32'h0000_000A; bus.R1 = 32'h0000_000B;
        tick();
        bubble();
        #1;
        chk("hi_val", HI_out, 32'h0000_000A);
        chk("lo_val", LO_out, 32'h0000_000B);
        chk("hilo_cnt", 32'(RetireCnt), 32'd5);

        // Display SYSCALL from committed v0/a0
        alu_write(REG_V0, 32'd34);
        tick();
        alu_write(REG_A0, 32'h0000_0055);
        tick();
        bubble();
        bus.IR = 32'h0000_000C; bus.SYSCALL = 1'b1;
        tick();
        bubble();
        #1;
        chk("disp_val", Display, 32'h0000_0055);
        chk("disp_nohalt", 32'(Halt), 32'h0);

        // Display SYSCALL picking up a0 through the bypass
        alu_write(REG_A0, 32'h0000_0077);
        bus.SYSCALL = 1'b1;
        tick();
        bubble();
        #1;
        chk("disp_bypass", Display, 32'h0000_0077);
        chk("disp_cnt", 32'(RetireCnt), 32'd9);

        // v0 <- 10 immediately before the halting SYSCALL
        alu_write(REG_V0, 32'd10);
        tick();
        bubble();
        bus.IR = 32'h0000_000C; bus.SYSCALL = 1'b1;
        #1;
        chk("halt_pre", 32'(Halt), 32'h0);
        tick();
        bubble();
        #1;
        chk("halt_set", 32'(Halt), 32'h1);
        chk("halt_cnt", 32'(RetireCnt), 32'd11);

        // Everything suppressed while halted; reads stay live without bypass
        alu_write(5'd8, 32'h0000_9999);
        bus.HIWrite = 1'b1; bus.R2 = 32'h0000_0001;
        RA1 = 5'd8;
        #1;
        chk("halt_nobypass", RD_A, 32'h0000_1234);
        tick();
        bubble();
        #1;
        chk("halt_r8", RD_A, 32'h0000_1234);
        chk("halt_hi", HI_out, 32'h0000_000A);
        chk("halt_cnt_frozen", 32'(RetireCnt), 32'd11);
        chk("halt_stays", 32'(Halt), 32'h1);

        // CLR out of HALT
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        RA1 = 5'd8; RA2 = 5'd31;
        #1;
        chk("clr_halt", 32'(Halt), 32'h0);
        chk("clr_r8", RD_A, 32'h0);
        chk("clr_r31", RD_B, 32'h0);
        chk("clr_hi", HI_out, 32'h0);
        chk("clr_lo", LO_out, 32'h0);
        chk("clr_disp", Display, 32'h0);
        chk("clr_cnt", 32'(RetireCnt), 32'h0);

        // Counter wrap with interleaved bubbles
        for (int i = 0; i < 15; i++) begin
            bubble();
            bus.IR = 32'h0000_0001;
            tick();
            bubble();
            tick();
        end
        #1;
        chk("cnt_15", 32'(RetireCnt), 32'd15);
        bubble();
        bus.IR = 32'h0000_0001;
        tick();
        bubble();
        tick();
        #1;
        chk("cnt_wrap", 32'(RetireCnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
